// File: rtl/rf_dump_pkg.sv
// Shared definitions for the register-file dump engine: state encoding and
// the default register-file geometry shared with the datapath.
package rf_dump_pkg;

    localparam int RF_NREG = 32;
    localparam int RF_AW   = 5;
    localparam int RF_DW   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } dump_state_e;

endpackage

// File: rtl/rf_dump.sv
// Debug read-out engine: stalls the CPU, walks register indices 0..NREG-1
// through one combinational read port and streams (index, value) pairs out
// over a valid/ready handshake. All outputs come straight from flops.
module rf_dump
    import rf_dump_pkg::*;
#(
    parameter int NREG = RF_NREG,
    parameter int AW   = RF_AW,
    parameter int DW   = RF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          halt_req,
    output logic          done,
    output logic [AW-1:0] rf_addr,
    input  logic [DW-1:0] rf_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_idx,
    output logic [DW-1:0] out_data
);

    // Index of the final register; reaching it ends the scan so the counter
    // never wraps.
    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    dump_state_e   state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW-1:0] out_idx_q, out_idx_d;
    logic [DW-1:0] out_data_q, out_data_d;

    // Next-state, scan counter and output-word capture.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        out_idx_d  = out_idx_q;
        out_data_d = out_data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                    idx_d   = '0;
                end
            end
            READ: begin
                // The CPU is stalled, so the read data is stable at this edge.
                out_data_d = rf_data;
                out_idx_d  = idx_q;
                state_d    = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any dump in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            out_idx_q  <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            out_idx_q  <= out_idx_d;
            out_data_q <= out_data_d;
        end
    end

    // Outputs decoded from registered state only. The read address is the
    // scan counter itself: it only changes when entering READ, so it holds
    // its last value everywhere else.
    assign busy      = (state_q != IDLE);
    assign halt_req  = busy;
    assign done      = (state_q == DONE);
    assign out_valid = (state_q == SEND);
    assign rf_addr   = idx_q;
    assign out_idx   = out_idx_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_rf_dump.sv
// Directed bench for rf_dump: a behavioural register file feeds the read
// port, and every accepted word is checked against the preloaded contents.
module tb_rf_dump;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;

    localparam int RM_HIGH  = 0;
    localparam int RM_RAND  = 1;
    localparam int RM_STALL = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          halt_req;
    logic          done;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_idx;
    logic [DW-1:0] out_data;

    logic [DW-1:0] rf_mem [NREG];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int ready_mode = RM_HIGH;
    int restart_idx = -1;
    int restart_hits = 0;
    int words_seen = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int s_cyc = -100;
    int stall_cnt = 0;
    bit stall_bad = 0;
    bit halt_bad = 0;
    bit in_dump = 0;
    logic first_busy, first_valid, second_valid;

    always #5 clk = ~clk;

    assign rf_data = rf_mem[rf_addr];

    rf_dump #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .halt_req  (halt_req),
        .done      (done),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic load_pattern(input int p);
        for (int i = 0; i < NREG; i++) begin
            case (p)
                0:       rf_mem[i] = 32'h0;
                1:       rf_mem[i] = 32'hA5A50000 | i;
                default: rf_mem[i] = 32'h10000000 + i * 32'h111;
            endcase
        end
        if (p == 0) begin
            rf_mem[28] = 32'h00001800;
            rf_mem[29] = 32'h00002ffe;
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, then sample outputs.
    task automatic tick(input logic st);
        @(negedge clk);
        cyc++;
        start = st;
        if (restart_idx >= 0 && out_valid && int'(out_idx) == restart_idx) begin
            start = 1'b1;
            restart_hits++;
        end
        case (ready_mode)
            RM_HIGH: out_ready = 1'b1;
            RM_RAND: out_ready = 1'($urandom_range(0, 1));
            default: begin
                if (out_valid && out_idx == 5'd3 && stall_cnt < 5) begin
                    out_ready = 1'b0;
                    stall_cnt++;
                    if (out_data !== rf_mem[3] || words_seen != 3) stall_bad = 1'b1;
                end else begin
                    out_ready = 1'b1;
                end
            end
        endcase
        if (cyc == s_cyc + 1) begin
            first_busy  = busy;
            first_valid = out_valid;
        end
        if (cyc == s_cyc + 2) second_valid = out_valid;
        if (halt_req !== busy) halt_bad = 1'b1;
        if (in_dump && halt_req !== 1'b1) halt_bad = 1'b1;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            in_dump  = 1'b0;
        end
        if (out_valid && out_ready) begin
            $display("word %0d: idx=%0d data=%08h", words_seen, out_idx, out_data);
            check_eq("word_idx", 32'(out_idx), 32'(words_seen));
            check_eq("word_data", out_data, rf_mem[words_seen % NREG]);
            words_seen++;
        end
    endtask

    // Full dump: nstart cycles of start, run to done, optional quiet tail.
    task automatic run_dump(input int nstart, input bit chk_timing, input bit skip_tail);
        int n;
        words_seen = 0;
        done_cnt   = 0;
        halt_bad   = 1'b0;
        stall_cnt  = 0;
        stall_bad  = 1'b0;
        s_cyc      = -100;
        first_busy = 1'bx;
        first_valid = 1'bx;
        second_valid = 1'bx;
        tick(1'b1);
        s_cyc   = cyc;
        in_dump = 1'b1;
        for (int i = 1; i < nstart; i++) tick(1'b1);
        n = 0;
        while (done_cnt == 0 && n < 2000) begin
            tick(1'b0);
            n++;
        end
        check_eq("done_seen", 32'(done_cnt), 32'd1);
        check_eq("busy_k1", 32'(first_busy), 32'd1);
        check_eq("valid_k1", 32'(first_valid), 32'd0);
        check_eq("word_count", 32'(words_seen), 32'(NREG));
        check_eq("halt_whole_dump", 32'(halt_bad), 32'd0);
        if (chk_timing) begin
            check_eq("valid_k2", 32'(second_valid), 32'd1);
            check_eq("done_cycle", 32'(done_cyc - s_cyc), 32'd65);
        end
        if (!skip_tail) begin
            for (int i = 0; i < 4; i++) tick(1'b0);
            check_eq("done_once", 32'(done_cnt), 32'd1);
            check_eq("idle_after", 32'(busy), 32'd0);
            check_eq("no_extra_words", 32'(words_seen), 32'(NREG));
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        load_pattern(0);

        // Reset state.
        @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_halt", 32'(halt_req), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_rf_addr", 32'(rf_addr), 32'd0);
        check_eq("rst_out_idx", 32'(out_idx), 32'd0);
        check_eq("rst_out_data", out_data, 32'd0);
        rst = 1'b0;
        tick(1'b0);

        // Basic dump with sparse preload and ready tied high.
        ready_mode = RM_HIGH;
        run_dump(1, 1'b1, 1'b0);

        // Backpressure on word 3.
        load_pattern(2);
        ready_mode = RM_STALL;
        run_dump(1, 1'b0, 1'b0);
        check_eq("stall_cycles", 32'(stall_cnt), 32'd5);
        check_eq("stall_stable", 32'(stall_bad), 32'd0);

        // Start pulsed again mid-dump is ignored.
        ready_mode  = RM_HIGH;
        restart_idx = 10;
        restart_hits = 0;
        run_dump(1, 1'b1, 1'b0);
        check_eq("restart_applied", 32'(restart_hits > 0), 32'd1);
        restart_idx = -1;

        // Reset while sending word 7.
        words_seen = 0;
        done_cnt   = 0;
        tick(1'b1);
        n = 0;
        while (!(out_valid && out_idx == 5'd7) && n < 200) begin
            tick(1'b0);
            n++;
        end
        check_eq("reach_idx7", 32'(out_idx), 32'd7);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_halt", 32'(halt_req), 32'd0);
        check_eq("mid_rst_done", 32'(done), 32'd0);
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_rf_addr", 32'(rf_addr), 32'd0);
        check_eq("mid_rst_out_idx", 32'(out_idx), 32'd0);
        check_eq("mid_rst_out_data", out_data, 32'd0);
        tick(1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b0);
        check_eq("mid_rst_no_done", 32'(done_cnt), 32'd0);
        check_eq("mid_rst_idle", 32'(busy), 32'd0);
        run_dump(1, 1'b1, 1'b0);

        // Random backpressure with an index-tagged preload.
        load_pattern(1);
        ready_mode = RM_RAND;
        run_dump(1, 1'b0, 1'b0);

        // Start held for three cycles gives one dump only.
        ready_mode = RM_HIGH;
        run_dump(3, 1'b1, 1'b0);

        // Back-to-back: start in the IDLE cycle right after done.
        run_dump(1, 1'b1, 1'b1);
        run_dump(1, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
